// File: rtl/m65c02_int_pkg.sv
// -----------------------------------------------------------------------------
// m65c02_int_pkg
// Shared definitions for the M65C02A interrupt / Set-Overflow front end:
//   - service state encoding (RST / IDLE / TAKEN)
//   - interrupt source encoding (RST / NMI / IRQ / BRK)
//   - default vector addresses and synchronizer depth
//   - helper mapping a service source onto its vector address
// -----------------------------------------------------------------------------
package m65c02_int_pkg;

    typedef enum logic [1:0] {
        ST_RST   = 2'd0,
        ST_IDLE  = 2'd1,
        ST_TAKEN = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SRC_RST = 2'd0,
        SRC_NMI = 2'd1,
        SRC_IRQ = 2'd2,
        SRC_BRK = 2'd3
    } src_t;

    localparam logic [15:0] RST_VEC_DFLT    = 16'hFFFC;
    localparam logic [15:0] NMI_VEC_DFLT    = 16'hFFFA;
    localparam logic [15:0] IRQ_VEC_DFLT    = 16'hFFFE;
    localparam int unsigned SYNC_DEPTH_DFLT = 2;

    // IRQ and BRK share a vector; the reset vector only applies to SRC_RST.
    function automatic logic [15:0] src_vector(
        input src_t        src,
        input logic [15:0] rst_vec,
        input logic [15:0] nmi_vec,
        input logic [15:0] irq_vec
    );
        logic [15:0] v;
        v = irq_vec;
        case (src)
            SRC_RST: v = rst_vec;
            SRC_NMI: v = nmi_vec;
            default: v = irq_vec;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/m65c02_pin_sync.sv
// -----------------------------------------------------------------------------
// m65c02_pin_sync
// Multi-flop synchronizer for one asynchronous, active-low pin, with a
// falling-edge detector on the synchronized value.
//
// Parameters:
//   pSyncDepth : number of synchronizer flops (minimum 2)
// Ports:
//   Clk  : core clock
//   nRst : synchronous reset, active low; presets all flops to 1 (pin idle)
//   Pin  : asynchronous pin input
//   Sync : synchronized pin level
//   Fall : one-cycle strobe, synchronized level went 1 -> 0
// -----------------------------------------------------------------------------
module m65c02_pin_sync #(
    parameter int unsigned pSyncDepth = 2
) (
    input  logic Clk,
    input  logic nRst,
    input  logic Pin,
    output logic Sync,
    output logic Fall
);

    logic [pSyncDepth-1:0] sync_q;
    logic                  sync_d;

    always_ff @(posedge Clk) begin
        if (!nRst) begin
            sync_q <= '1;
            sync_d <= 1'b1;
        end else begin
            sync_q <= {sync_q[pSyncDepth-2:0], Pin};
            sync_d <= sync_q[pSyncDepth-1];
        end
    end

    assign Sync = sync_q[pSyncDepth-1];
    // Previous-cycle copy of the synchronized level makes the edge strobe a
    // pure function of registers.
    assign Fall = sync_d & ~Sync;

endmodule

// File: rtl/m65c02_int_ctrl.sv
// -----------------------------------------------------------------------------
// m65c02_int_ctrl
// Interrupt and Set-Overflow front end of the M65C02A core. Synchronizes the
// nNMI, nIRQ and nSO pins, edge-detects NMI and SO, arbitrates reset / NMI /
// IRQ / BRK at instruction boundaries and supplies the vector address. Feeds
// ISR and SO to the processor status word and consumes Clr_SO and I back.
//
// Optional feature (macro M65C02A_WAI_WAKE_EN):
//   defined   : Wake = registered (NMI_Lat | nIRQ asserted), I mask ignored
//   undefined : Wake tied low, port retained
//
// Ports:
//   Clk      in   core clock
//   nRst     in   synchronous reset, active low
//   Rdy      in   core ready; low stalls the service state machine
//   nNMI     in   async NMI pin, falling-edge sensitive
//   nIRQ     in   async IRQ pin, level sensitive, active low
//   nSO      in   async Set-Overflow pin, falling-edge sensitive
//   I        in   interrupt mask (P[2])
//   IntSvc   in   sequencer at instruction boundary, accepting interrupt
//   BRK      in   BRK opcode decoded at this boundary
//   VecFetch in   sequencer fetching vector low byte
//   Clr_SO   in   status word has consumed SO
//   SO       out  latched SO request
//   Int      out  interrupt pending (NMI latch | unmasked IRQ)
//   ISR      out  one-cycle ISR-entry strobe
//   Vector   out  vector address of the current service
//   Wake     out  WAI wake-up request
// -----------------------------------------------------------------------------
module m65c02_int_ctrl
    import m65c02_int_pkg::*;
#(
    parameter logic [15:0] pRST_Vec   = RST_VEC_DFLT,
    parameter logic [15:0] pNMI_Vec   = NMI_VEC_DFLT,
    parameter logic [15:0] pIRQ_Vec   = IRQ_VEC_DFLT,
    parameter int unsigned pSyncDepth = SYNC_DEPTH_DFLT
) (
    input  logic        Clk,
    input  logic        nRst,
    input  logic        Rdy,
    input  logic        nNMI,
    input  logic        nIRQ,
    input  logic        nSO,
    input  logic        I,
    input  logic        IntSvc,
    input  logic        BRK,
    input  logic        VecFetch,
    input  logic        Clr_SO,
    output logic        SO,
    output logic        Int,
    output logic        ISR,
    output logic [15:0] Vector,
    output logic        Wake
);

    // -------------------------------------------------------------------------
    // Pin synchronizers (free running, independent of Rdy)
    // -------------------------------------------------------------------------
    logic nmi_sync, nmi_fall;
    logic irq_sync, irq_fall;
    logic so_sync,  so_fall;

    m65c02_pin_sync #(.pSyncDepth(pSyncDepth)) u_sync_nmi (
        .Clk  (Clk),
        .nRst (nRst),
        .Pin  (nNMI),
        .Sync (nmi_sync),
        .Fall (nmi_fall)
    );

    m65c02_pin_sync #(.pSyncDepth(pSyncDepth)) u_sync_irq (
        .Clk  (Clk),
        .nRst (nRst),
        .Pin  (nIRQ),
        .Sync (irq_sync),
        .Fall (irq_fall)
    );

    m65c02_pin_sync #(.pSyncDepth(pSyncDepth)) u_sync_so (
        .Clk  (Clk),
        .nRst (nRst),
        .Pin  (nSO),
        .Sync (so_sync),
        .Fall (so_fall)
    );

    // Only the edge strobe of nNMI/nSO and the level of nIRQ are consumed.
    logic unused_sync;
    assign unused_sync = ^{nmi_sync, irq_fall, so_sync};

    // -------------------------------------------------------------------------
    // Request latches
    // -------------------------------------------------------------------------
    logic nmi_lat;
    logic so_lat;
    logic nmi_clr;
    logic irq_req;

    // Set terms are OR-ed after the clear so a coincident new edge wins and
    // no NMI or SO request is lost.
    always_ff @(posedge Clk) begin
        if (!nRst) begin
            nmi_lat <= 1'b0;
            so_lat  <= 1'b0;
        end else begin
            nmi_lat <= (nmi_lat & ~nmi_clr) | nmi_fall;
            so_lat  <= (so_lat  & ~Clr_SO)  | so_fall;
        end
    end

    assign irq_req = ~irq_sync & ~I;
    assign Int     = nmi_lat | irq_req;
    assign SO      = so_lat;

    // -------------------------------------------------------------------------
    // Service state machine
    // -------------------------------------------------------------------------
    state_t      state_q, state_d;
    src_t        src_q,   src_d;
    logic [15:0] vec_q,   vec_d;
    logic        isr;

    always_ff @(posedge Clk) begin
        if (!nRst) begin
            state_q <= ST_RST;
            src_q   <= SRC_RST;
            vec_q   <= pRST_Vec;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            vec_q   <= vec_d;
        end
    end

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        vec_d   = vec_q;
        isr     = 1'b0;
        nmi_clr = 1'b0;

        unique case (state_q)
            ST_RST: begin
                vec_d = pRST_Vec;
                if (VecFetch && Rdy) begin
                    isr     = 1'b1;
                    state_d = ST_IDLE;
                end
            end

            ST_IDLE: begin
                if (IntSvc && Rdy) begin
                    if (nmi_lat) begin
                        src_d   = SRC_NMI;
                        state_d = ST_TAKEN;
                    end else if (irq_req) begin
                        src_d   = SRC_IRQ;
                        state_d = ST_TAKEN;
                    end else if (BRK) begin
                        src_d   = SRC_BRK;
                        state_d = ST_TAKEN;
                    end
                    if (state_d == ST_TAKEN) begin
                        vec_d = src_vector(src_d, pRST_Vec, pNMI_Vec, pIRQ_Vec);
                    end
                end
            end

            ST_TAKEN: begin
                // Vector stays frozen here regardless of nIRQ or I changes.
                if (VecFetch && Rdy) begin
                    isr     = 1'b1;
                    nmi_clr = (src_q == SRC_NMI);
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_RST;
                src_d   = SRC_RST;
                vec_d   = pRST_Vec;
            end
        endcase
    end

    // Gated by nRst so the strobe cannot leak out while reset is being applied.
    assign ISR    = isr & nRst;
    assign Vector = vec_q;

    // -------------------------------------------------------------------------
    // WAI wake-up
    // -------------------------------------------------------------------------
`ifdef M65C02A_WAI_WAKE_EN
    logic wake_q;

    always_ff @(posedge Clk) begin
        if (!nRst) begin
            wake_q <= 1'b0;
        end else begin
            wake_q <= nmi_lat | ~irq_sync;
        end
    end

    assign Wake = wake_q;
`else
    assign Wake = 1'b0;
`endif

endmodule
